// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / stall / flush controller.
// Detects register read-after-write hazards against in-flight writers and
// arbitrates memory-wait freezes, branch flushes, hazard stalls and the
// HALT drain sequence.
// Optional build macro: HAZ_FWD_EN (forwarding present, so only a load in
// ID/EX can cause a one-cycle load-use stall).
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic        rs_used,
    input  logic        rt_used,
    input  logic [2:0]  writeRegSel_ID_EX,
    input  logic [2:0]  writeRegSel_EX_MEM,
    input  logic [2:0]  writeRegSel_MEM_WB,
    input  logic        RegWrite_ID_EX,
    input  logic        RegWrite_EX_MEM,
    input  logic        RegWrite_MEM_WB,
    input  logic        MemRead_ID_EX,
    input  logic        br_taken,
    input  logic        mem_busy,
    input  logic        halt_id,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic        freeze,
    output logic        halted,
    output logic        err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wdog_q, wdog_d;
    logic [1:0]  drain_q, drain_d;
    logic        err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        haz;
    logic        eval_run;
    logic        stall_pc_c, stall_if_id_c, bubble_c, flush_c, freeze_c, halted_c;

    // True when a writing stage targets a register the ID instruction reads.
    function automatic logic src_match(
        input logic [2:0] dst,
        input logic       wr,
        input logic [2:0] s_rs,
        input logic       s_rs_used,
        input logic [2:0] s_rt,
        input logic       s_rt_used
    );
        return wr && ((s_rs_used && (s_rs == dst)) || (s_rt_used && (s_rt == dst)));
    endfunction

`ifdef HAZ_FWD_EN
    // With forwarding only a load in EX can leave a value unavailable to ID.
    always_comb begin
        haz = MemRead_ID_EX &&
              src_match(writeRegSel_ID_EX, RegWrite_ID_EX, rs, rs_used, rt, rt_used);
    end
`else
    // MemRead only matters when forwarding is present.
    logic mem_read_unused;
    assign mem_read_unused = MemRead_ID_EX;

    // Without forwarding any pending writer in EX, MEM or WB blocks the read.
    always_comb begin
        haz = src_match(writeRegSel_ID_EX,  RegWrite_ID_EX,  rs, rs_used, rt, rt_used) ||
              src_match(writeRegSel_EX_MEM, RegWrite_EX_MEM, rs, rs_used, rt, rt_used) ||
              src_match(writeRegSel_MEM_WB, RegWrite_MEM_WB, rs, rs_used, rt, rt_used);
    end
`endif

    // Next-state and output decode; priority mem_busy > br_taken > hazard > halt.
    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        drain_d       = drain_q;
        err_d         = err_q;
        stall_cnt_d   = stall_cnt_q;
        eval_run      = 1'b0;
        stall_pc_c    = 1'b0;
        stall_if_id_c = 1'b0;
        bubble_c      = 1'b0;
        flush_c       = 1'b0;
        freeze_c      = 1'b0;
        halted_c      = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    freeze_c = 1'b1;
                    state_d  = MWAIT;
                end else begin
                    eval_run = 1'b1;
                end
            end
            MWAIT: begin
                if (mem_busy) begin
                    freeze_c = 1'b1;
                    // Saturate so a stuck memory cannot wrap the watchdog.
                    if (wdog_q != 8'hFF) begin
                        wdog_d = wdog_q + 8'd1;
                    end
                    if (wdog_d == 8'hFF) begin
                        err_d = 1'b1;
                    end
                end else begin
                    // Memory finished: the pipeline moves this cycle, so the
                    // normal hazard arbitration applies on the way out.
                    wdog_d   = 8'd0;
                    state_d  = RUN;
                    eval_run = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    // Frozen: the drain count holds until memory completes.
                    freeze_c = 1'b1;
                end else if (br_taken) begin
                    // The HALT was on a wrong path; abandon it.
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    drain_d  = 2'd0;
                    state_d  = RUN;
                end else begin
                    stall_pc_c    = 1'b1;
                    stall_if_id_c = 1'b1;
                    drain_d       = drain_q - 2'd1;
                    if (drain_q <= 2'd1) begin
                        drain_d = 2'd0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                halted_c      = 1'b1;
                stall_pc_c    = 1'b1;
                stall_if_id_c = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (eval_run) begin
            if (br_taken) begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
            end else if (haz) begin
                stall_pc_c    = 1'b1;
                stall_if_id_c = 1'b1;
                bubble_c      = 1'b1;
                if (stall_cnt_q != 16'hFFFF) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end else if (halt_id) begin
                // Hold fetch and let the three older instructions retire.
                stall_pc_c    = 1'b1;
                stall_if_id_c = 1'b1;
                drain_d       = 2'd3;
                state_d       = DRAIN;
            end
        end
    end

    // State, counters and sticky error, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wdog_q      <= 8'd0;
            drain_q     <= 2'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            drain_q     <= drain_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational controls are gated so reset silences them at once.
    assign stall_pc     = rst_n & stall_pc_c;
    assign stall_if_id  = rst_n & stall_if_id_c;
    assign bubble_id_ex = rst_n & bubble_c;
    assign flush_if_id  = rst_n & flush_c;
    assign freeze       = rst_n & freeze_c;
    assign halted       = rst_n & halted_c;
    assign err          = err_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. Each cycle's expected
// outputs are queued when inputs are driven and compared on the falling edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  rs, rt;
    logic        rs_used, rt_used;
    logic [2:0]  wsel_idex, wsel_exmem, wsel_memwb;
    logic        rw_idex, rw_exmem, rw_memwb;
    logic        mem_read, br_taken, mem_busy, halt_id;
    logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze, halted, err;
    logic [15:0] stall_cnt;
    logic [6:0]  outs;

    // Output vector order: stall_pc stall_if_id bubble flush freeze halted err
    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_STALL = 7'b1110000;
    localparam logic [6:0] O_FLUSH = 7'b0011000;
    localparam logic [6:0] O_FRZ   = 7'b0000100;
    localparam logic [6:0] O_HOLD  = 7'b1100000;
    localparam logic [6:0] O_DONE  = 7'b1100010;
    localparam logic [6:0] O_ERR   = 7'b0000001;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] exp_cnt;
    string       q_tag[$];
    logic [6:0]  q_out[$];
    logic [15:0] q_cnt[$];

    always #5 clk = ~clk;

    assign outs = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze, halted, err};

    hazard_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rs                 (rs),
        .rt                 (rt),
        .rs_used            (rs_used),
        .rt_used            (rt_used),
        .writeRegSel_ID_EX  (wsel_idex),
        .writeRegSel_EX_MEM (wsel_exmem),
        .writeRegSel_MEM_WB (wsel_memwb),
        .RegWrite_ID_EX     (rw_idex),
        .RegWrite_EX_MEM    (rw_exmem),
        .RegWrite_MEM_WB    (rw_memwb),
        .MemRead_ID_EX      (mem_read),
        .br_taken           (br_taken),
        .mem_busy           (mem_busy),
        .halt_id            (halt_id),
        .stall_pc           (stall_pc),
        .stall_if_id        (stall_if_id),
        .bubble_id_ex       (bubble_id_ex),
        .flush_if_id        (flush_if_id),
        .freeze             (freeze),
        .halted             (halted),
        .err                (err),
        .stall_cnt          (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        rs = 3'd0; rt = 3'd0; rs_used = 1'b0; rt_used = 1'b0;
        wsel_idex = 3'd0; wsel_exmem = 3'd0; wsel_memwb = 3'd0;
        rw_idex = 1'b0; rw_exmem = 1'b0; rw_memwb = 1'b0;
        mem_read = 1'b0; br_taken = 1'b0; mem_busy = 1'b0; halt_id = 1'b0;
    endtask

    // One clock: queue expectation, compare at negedge, return after next posedge.
    task automatic cyc(input string tag, input logic [6:0] eo, input bit counts);
        string       t;
        logic [6:0]  o;
        logic [15:0] c;
        q_tag.push_back(tag);
        q_out.push_back(eo);
        q_cnt.push_back(exp_cnt);
        if (counts) exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        t = q_tag.pop_front();
        o = q_out.pop_front();
        c = q_cnt.pop_front();
        check_eq({t, "_out"}, {25'd0, outs}, {25'd0, o});
        check_eq({t, "_cnt"}, {16'd0, stall_cnt}, {16'd0, c});
        $display("cycle %s outs=%b cnt=%0d", t, outs, stall_cnt);
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, confirm outputs drop at once, then release.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_out"}, {25'd0, outs}, 32'd0);
        check_eq({tag, "_cnt"}, {16'd0, stall_cnt}, 32'd0);
        clr_in();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = 16'd0;
    endtask

    initial begin
        clr_in();
        exp_cnt  = 16'd0;
        rst_n    = 1'b0;
        mem_busy = 1'b1;
        br_taken = 1'b1;
        halt_id  = 1'b1;
        #12;
        check_eq("rst_out", {25'd0, outs}, 32'd0);
        check_eq("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        clr_in();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Producer of r2 walking down the pipe.
        rs = 3'd2; rs_used = 1'b1;
`ifndef HAZ_FWD_EN
        wsel_idex = 3'd2; rw_idex = 1'b1;
        cyc("haz_idex", O_STALL, 1);
        wsel_idex = 3'd0; rw_idex = 1'b0; wsel_exmem = 3'd2; rw_exmem = 1'b1;
        cyc("haz_exmem", O_STALL, 1);
        wsel_exmem = 3'd0; rw_exmem = 1'b0; wsel_memwb = 3'd2; rw_memwb = 1'b1;
        cyc("haz_memwb", O_STALL, 1);
        wsel_memwb = 3'd0; rw_memwb = 1'b0;
        cyc("haz_clear", O_NONE, 0);
        check_eq("cnt_pipe", {16'd0, stall_cnt}, 32'd3);
`else
        wsel_idex = 3'd2; rw_idex = 1'b1;
        cyc("fwd_idex", O_NONE, 0);
        wsel_idex = 3'd0; rw_idex = 1'b0; wsel_exmem = 3'd2; rw_exmem = 1'b1;
        cyc("fwd_exmem", O_NONE, 0);
        wsel_exmem = 3'd0; rw_exmem = 1'b0; wsel_memwb = 3'd2; rw_memwb = 1'b1;
        cyc("fwd_memwb", O_NONE, 0);
        wsel_memwb = 3'd0; rw_memwb = 1'b0;
        wsel_idex = 3'd2; rw_idex = 1'b1; mem_read = 1'b1;
        cyc("ldu_idex", O_STALL, 1);
        wsel_idex = 3'd0; rw_idex = 1'b0; mem_read = 1'b0; wsel_exmem = 3'd2; rw_exmem = 1'b1;
        cyc("ldu_exmem", O_NONE, 0);
        wsel_exmem = 3'd0; rw_exmem = 1'b0;
        cyc("ldu_clear", O_NONE, 0);
        check_eq("cnt_pipe", {16'd0, stall_cnt}, 32'd1);
`endif

        // rt source, RegWrite gating, unused field.
        rs_used = 1'b0; rt = 3'd5; rt_used = 1'b1;
        wsel_idex = 3'd5; rw_idex = 1'b1; mem_read = 1'b1;
        cyc("haz_rt", O_STALL, 1);
        rw_idex = 1'b0;
        cyc("no_regwrite", O_NONE, 0);
        rw_idex = 1'b1; rt_used = 1'b0;
        cyc("rt_unused", O_NONE, 0);

        // Branch beats a simultaneous hazard.
        rt_used = 1'b1; br_taken = 1'b1;
        cyc("br_haz", O_FLUSH, 0);
        clr_in();
        cyc("br_after", O_NONE, 0);

        // Memory busy for four cycles, branch suppressed while frozen.
        mem_busy = 1'b1; br_taken = 1'b1;
        cyc("mb_0", O_FRZ, 0);
        br_taken = 1'b0;
        for (int i = 1; i < 4; i++) cyc($sformatf("mb_%0d", i), O_FRZ, 0);
        mem_busy = 1'b0;
        cyc("mb_exit", O_NONE, 0);
        cyc("mb_run", O_NONE, 0);

        // HALT: halted exactly four cycles after the pulse, then sticky.
        halt_id = 1'b1;
        cyc("halt", O_HOLD, 0);
        halt_id = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("drain_%0d", i), O_HOLD, 0);
        cyc("done", O_DONE, 0);
        br_taken = 1'b1;
        cyc("done_br", O_DONE, 0);
        do_reset("rst_done");

        // Branch in DRAIN aborts the halt and returns to RUN.
        halt_id = 1'b1;
        cyc("halt_a", O_HOLD, 0);
        halt_id = 1'b0;
        cyc("drain_a", O_HOLD, 0);
        br_taken = 1'b1;
        cyc("abort", O_FLUSH, 0);
        br_taken = 1'b0; rs = 3'd2; rs_used = 1'b1;
        wsel_idex = 3'd2; rw_idex = 1'b1; mem_read = 1'b1;
        cyc("run_again", O_STALL, 1);
        clr_in();
        cyc("run_clear", O_NONE, 0);

        // Reset in the middle of a drain.
        halt_id = 1'b1;
        cyc("halt_r", O_HOLD, 0);
        halt_id = 1'b0;
        cyc("drain_r", O_HOLD, 0);
        do_reset("rst_drain");
        cyc("post_drain_rst", O_NONE, 0);

        // Freeze during drain holds the drain counter.
        halt_id = 1'b1;
        cyc("halt_f", O_HOLD, 0);
        halt_id = 1'b0; mem_busy = 1'b1;
        cyc("drain_frz0", O_FRZ, 0);
        cyc("drain_frz1", O_FRZ, 0);
        mem_busy = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("drain_f%0d", i), O_HOLD, 0);
        cyc("done_f", O_DONE, 0);
        do_reset("rst_done_f");

        // Watchdog: err from the 256th MWAIT cycle (busy cycle 257), sticky.
        mem_busy = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            cyc($sformatf("wdog_%0d", i), (i >= 257) ? (O_FRZ | O_ERR) : O_FRZ, 0);
        end
        mem_busy = 1'b0;
        cyc("wd_exit", O_ERR, 0);
        cyc("err_sticky", O_ERR, 0);
        do_reset("rst_err");

        // Reset while waiting on memory resumes cleanly in RUN.
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("mw_%0d", i), O_FRZ, 0);
        mem_busy = 1'b1;
        do_reset("rst_mwait");
        cyc("post_mwait_rst", O_NONE, 0);
        cyc("post_mwait_run", O_NONE, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
